// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// State encodings are fixed so external checkers can decode dbg_state.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_LANE0 = 4'b0001;

    // Byte enable for little-endian lane k.
    function automatic logic [3:0] lane_be(input logic [1:0] k);
        return BE_LANE0 << k;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane steering for stores and lane extraction with sign extension for lb.
// Purely combinational; the bus is fixed at four byte lanes.
module byte_lane_unit
    import mips_mem_pkg::*;
(
    input  logic        wb,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic        ld_wb,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] ld_data
);

    logic [7:0] ld_byte;

    always_comb begin
        be         = wb ? lane_be(lane) : BE_WORD;
        // Replicating the byte lets the memory pick it up from whichever lane is enabled.
        lane_wdata = wb ? {4{wdata[7:0]}} : wdata;
        case (ld_lane)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_data    = ld_wb ? {{24{ld_byte[7]}}, ld_byte} : rdata;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and data accesses,
// with data priority, registered bus outputs and a combinational pipeline stall.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic              dm_wb,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output state_t            dbg_state
);

    state_t            state;
    logic              ld_wb_q;
    logic [1:0]        ld_lane_q;
    logic [3:0]        dm_be;
    logic [DATA_W-1:0] dm_lane_wdata;
    logic [DATA_W-1:0] dm_ld_data;

    byte_lane_unit u_lanes (
        .wb         (dm_wb),
        .lane       (dm_addr[1:0]),
        .wdata      (dm_wdata),
        .ld_wb      (ld_wb_q),
        .ld_lane    (ld_lane_q),
        .rdata      (bus_rdata),
        .be         (dm_be),
        .lane_wdata (dm_lane_wdata),
        .ld_data    (dm_ld_data)
    );

    assign stall     = (if_req & ~if_ready) | (dm_req & ~dm_ready);
    assign dbg_state = state;

    // A grant only happens from IDLE, so every completion leaves one IDLE cycle
    // (the ready cycle) in which the just-served requester is masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            ld_wb_q   <= 1'b0;
            ld_lane_q <= 2'd0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (dm_req && !dm_ready) begin
                        state     <= DM_BUSY;
                        bus_req   <= 1'b1;
                        bus_we    <= dm_we;
                        bus_be    <= dm_be;
                        bus_addr  <= {dm_addr[ADDR_W-1:2], 2'b00};
                        bus_wdata <= dm_lane_wdata;
                        ld_wb_q   <= dm_wb;
                        ld_lane_q <= dm_addr[1:0];
                    end else if (if_req && !if_ready) begin
                        state     <= IF_BUSY;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_be    <= BE_WORD;
                        bus_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
                        bus_wdata <= '0;
                    end
                end
                IF_BUSY: begin
                    if (bus_ack) begin
                        state    <= IDLE;
                        bus_req  <= 1'b0;
                        if_ready <= 1'b1;
                        if_rdata <= bus_rdata;
                    end
                end
                DM_BUSY: begin
                    if (bus_ack) begin
                        state    <= IDLE;
                        bus_req  <= 1'b0;
                        dm_ready <= 1'b1;
                        // Stores return nothing useful, so the last load result is kept.
                        if (!bus_we) dm_rdata <= dm_ld_data;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

    // Requesters must hold req until their ready pulse; the transaction completes regardless.
    a_dm_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state == DM_BUSY) |-> dm_req)
        else $error("dm_req dropped during a data transaction");

    a_if_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state == IF_BUSY) |-> if_req)
        else $error("if_req dropped during a fetch");

    a_if_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        if_req |-> (if_addr[1:0] == 2'b00))
        else $error("fetch address not word-aligned");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single transactions
// plus hand-written sequences for contention, spurious ack and mid-transaction reset.
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic        dm_wb;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_dm;
        logic        we;
        logic        wb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        chk_rd;
    } vec_t;

    vec_t vecs[12];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_wb     (dm_wb),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_be    (bus_be),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives one transaction: req at cycle 0, grant visible cycle 1, ack after v.waits
    // wait cycles, ready pulse 2+waits cycles after req, req dropped the cycle after.
    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_wb = v.wb; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        bus_ack = 1'b0;
        #1;
        chk({p, " stall_req"}, stall, 1'b1);
        chk({p, " bus_req_c0"}, bus_req, 1'b0);
        for (int i = 0; i <= v.waits; i++) begin
            @(negedge clk);
            bus_ack   = (i == v.waits);
            bus_rdata = (i == v.waits) ? v.rdata : $urandom;
            #1;
            chk($sformatf("%s bus_req_w%0d", p, i), bus_req, 1'b1);
            chk($sformatf("%s bus_addr_w%0d", p, i), bus_addr, v.exp_addr);
            chk($sformatf("%s bus_be_w%0d", p, i), bus_be, v.exp_be);
            chk($sformatf("%s bus_we_w%0d", p, i), bus_we, v.we & v.is_dm);
            chk($sformatf("%s bus_wdata_w%0d", p, i), bus_wdata, v.exp_wdata);
            chk($sformatf("%s ready_w%0d", p, i), {if_ready, dm_ready}, 2'b00);
            chk($sformatf("%s state_w%0d", p, i), dbg_state, v.is_dm ? DM_BUSY : IF_BUSY);
        end
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk({p, " ready"}, {if_ready, dm_ready}, v.is_dm ? 2'b01 : 2'b10);
        chk({p, " stall_ready"}, stall, 1'b0);
        chk({p, " bus_req_done"}, bus_req, 1'b0);
        chk({p, " state_ready"}, dbg_state, IDLE);
        if (v.chk_rd) chk({p, " rdata"}, v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
        @(negedge clk);
        dm_req = 1'b0;
        if_req = 1'b0;
        #1;
        chk({p, " ready_once"}, {if_ready, dm_ready}, 2'b00);
        chk({p, " no_regrant"}, bus_req, 1'b0);
    endtask

    initial begin
        // is_dm we wb addr wdata rdata waits be exp_addr exp_wdata exp_rdata chk_rd
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h100, 32'h0,        32'h2402000A, 0, 4'hF, 32'h100, 32'h0,        32'h2402000A, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h204, 32'hCAFEBABE, 32'h0,        0, 4'hF, 32'h204, 32'hCAFEBABE, 32'h0,        1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h207, 32'h01234567, 32'h0,        0, 4'hF, 32'h204, 32'h01234567, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h203, 32'h000000A5, 32'h0,        0, 4'h8, 32'h200, 32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h200, 32'h12345678, 32'h0,        1, 4'h1, 32'h200, 32'h78787878, 32'h0,        1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h201, 32'h0,        32'h11228344, 0, 4'h2, 32'h200, 32'h0,        32'hFFFFFF83, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h201, 32'h0,        32'h11227F44, 0, 4'h2, 32'h200, 32'h0,        32'h0000007F, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h20A, 32'h0,        32'h89ABCDEF, 0, 4'hF, 32'h208, 32'h0,        32'h89ABCDEF, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h20B, 32'h0,        32'h80000000, 0, 4'h8, 32'h208, 32'h0,        32'hFFFFFF80, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h20E, 32'h0,        32'h00420000, 2, 4'h4, 32'h20C, 32'h0,        32'h00000042, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h104, 32'h0,        32'h8C220004, 5, 4'hF, 32'h104, 32'h0,        32'h8C220004, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h300, 32'h0,        32'h5A5A0FF0, 5, 4'hF, 32'h300, 32'h0,        32'h5A5A0FF0, 1'b1};

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_wb = 1'b0;
        dm_addr = '0; dm_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst bus_req", bus_req, 1'b0);
        chk("rst bus_be", bus_be, 4'h0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chk("rst readys", {if_ready, dm_ready}, 2'b00);
        chk("rst rdata", if_rdata | dm_rdata, 32'h0);
        chk("rst state", dbg_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Contention: both rise together, DM wins, IF follows after one IDLE cycle.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        dm_req = 1'b1; dm_we = 1'b0; dm_wb = 1'b0; dm_addr = 32'h200;
        #1;
        chk("ct stall_c0", stall, 1'b1);
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        #1;
        chk("ct dm_first", bus_addr, 32'h200);
        chk("ct dm_state", dbg_state, DM_BUSY);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("ct dm_ready", {if_ready, dm_ready}, 2'b01);
        chk("ct dm_rdata", dm_rdata, 32'hDEADBEEF);
        chk("ct stall_if_pending", stall, 1'b1);
        chk("ct idle_gap", bus_req, 1'b0);
        @(negedge clk);
        dm_req = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        #1;
        chk("ct if_granted", bus_req, 1'b1);
        chk("ct if_addr", bus_addr, 32'h100);
        chk("ct if_state", dbg_state, IF_BUSY);
        chk("ct stall_if_busy", stall, 1'b1);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("ct if_ready", {if_ready, dm_ready}, 2'b10);
        chk("ct if_rdata", if_rdata, 32'h12345678);
        chk("ct stall_low", stall, 1'b0);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        chk("ct quiet", {bus_req, if_ready, dm_ready}, 3'b000);

        // Spurious ack in IDLE must not complete anything.
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("sp readys", {if_ready, dm_ready}, 2'b00);
        chk("sp state", dbg_state, IDLE);
        chk("sp dm_rdata_kept", dm_rdata, 32'hDEADBEEF);

        // Reset during DM_BUSY aborts the transaction at once.
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_wb = 1'b0; dm_addr = 32'h400; dm_wdata = 32'h55AA55AA;
        @(negedge clk);
        #1;
        chk("rs busy", dbg_state, DM_BUSY);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs bus_req_drop", bus_req, 1'b0);
        chk("rs state_idle", dbg_state, IDLE);
        chk("rs dm_rdata_clr", dm_rdata, 32'h0);
        dm_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rs after_release", {bus_req, if_ready, dm_ready}, 3'b000);
        chk("rs state_after", dbg_state, IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
